// File: rtl/systolic_host_driver.sv
// Purpose     : host-side driver for the 4x4 systolic MAC; latches A/B, arms the array,
//               streams operand beats and captures result beats into a 16x32 buffer.
// Latency     : >= 14 cycles start->done (1 arm, 4 operand, 8 result, 1 done); res_data 1 cycle.
// Backpressure: operand beat held stable while mac_dest_ready=0; result side always ready in
//               WAIT_RX; TIMEOUT idle cycles on either handshake abort the job with err_timeout.
//
// Ports:
//   clk, reset        rising-edge clock, async active-low reset
//   cfg_a, cfg_b      4x4 signed int8 matrices, element [r][c] at bits [127-8*(4r+c) -: 8]
//   start             job request, honoured only in IDLE
//   busy/done/err_timeout   job status (done is a 1-cycle pulse, err_timeout is sticky)
//   mac_valid_in      1-cycle arm strobe to the array
//   mac_data, mac_src_valid, mac_dest_ready     operand beat handshake (driver -> array)
//   mac_data_out, mac_dest_valid, mac_src_ready result beat handshake (array -> driver)
//   res_addr, res_data   registered read port into the result buffer (row*4+col)
//   cycle_count       busy cycles of the last job, saturating

module systolic_host_driver #(
  parameter int N_TX_BEATS = 4,
  parameter int N_RX_BEATS = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] cfg_a,
  input  logic [127:0] cfg_b,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err_timeout,
  output logic         mac_valid_in,
  output logic [63:0]  mac_data,
  output logic         mac_src_valid,
  input  logic         mac_dest_ready,
  input  logic         mac_dest_valid,
  input  logic [63:0]  mac_data_out,
  output logic         mac_src_ready,
  input  logic [3:0]   res_addr,
  output logic [31:0]  res_data,
  output logic [15:0]  cycle_count
);

  localparam int TXW = $clog2(N_TX_BEATS);
  localparam int RXW = $clog2(N_RX_BEATS);
  localparam int TOW = $clog2(TIMEOUT + 1);

  localparam logic [TXW-1:0] TX_LAST = TXW'(N_TX_BEATS - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(N_RX_BEATS - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SEND,
    S_WAIT_RX,
    S_FIN
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [127:0]   a_q;
  logic [127:0]   b_q;
  logic [TXW-1:0] tx_cnt;
  logic [RXW-1:0] rx_cnt;
  logic [TOW-1:0] to_cnt;
  logic [31:0]    result [16];
  logic [63:0]    beat;

  logic start_acc;
  logic tx_fire;
  logic rx_fire;
  logic stalled;
  logic to_hit;

  // Handshake qualifiers. Valid/ready on the driver side are pure state
  // decodes, so a fire only needs the state plus the array's signal.
  assign start_acc = (state == S_IDLE) && start;
  assign tx_fire   = (state == S_SEND) && mac_dest_ready;
  assign rx_fire   = (state == S_WAIT_RX) && mac_dest_valid;
  assign stalled   = ((state == S_SEND) && !mac_dest_ready) ||
                     ((state == S_WAIT_RX) && !mac_dest_valid);
  // Fires on the TIMEOUT-th consecutive stall cycle of the current state.
  assign to_hit    = stalled && (to_cnt == TO_LAST);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_ARM;
      S_ARM:     state_nxt = S_SEND;
      S_SEND: begin
        if (tx_fire && (tx_cnt == TX_LAST)) state_nxt = S_WAIT_RX;
        else if (to_hit)                    state_nxt = S_IDLE;
      end
      S_WAIT_RX: begin
        if (rx_fire && (rx_cnt == RX_LAST)) state_nxt = S_FIN;
        else if (to_hit)                    state_nxt = S_IDLE;
      end
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Operand beat k: row k of A in the upper word, column k of B in the lower
  // word, first element in the most significant byte of each half.
  always_comb begin
    beat        = '0;
    beat[63:32] = a_q[127 - 32*int'(tx_cnt) -: 32];
    for (int r = 0; r < 4; r++) begin
      beat[31 - 8*r -: 8] = b_q[127 - 8*(4*r + int'(tx_cnt)) -: 8];
    end
  end

  // Outputs are decodes of the state register; mac_data is forced to zero
  // outside SEND so idle/reset values are clean.
  assign busy          = (state == S_ARM) || (state == S_SEND) || (state == S_WAIT_RX);
  assign done          = (state == S_FIN);
  assign mac_valid_in  = (state == S_ARM);
  assign mac_src_valid = (state == S_SEND);
  assign mac_src_ready = (state == S_WAIT_RX);
  assign mac_data      = (state == S_SEND) ? beat : 64'd0;

  // Control state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= state_nxt;

      if (start_acc) begin
        a_q <= cfg_a;
        b_q <= cfg_b;
      end

      if (start_acc)    tx_cnt <= '0;
      else if (tx_fire) tx_cnt <= tx_cnt + 1'b1;

      if (start_acc)    rx_cnt <= '0;
      else if (rx_fire) rx_cnt <= rx_cnt + 1'b1;

      // Idle counter restarts on any handshake or state change so each
      // handshake gets a full TIMEOUT window.
      if ((state_nxt != state) || tx_fire || rx_fire) to_cnt <= '0;
      else if (stalled)                               to_cnt <= to_cnt + 1'b1;

      if (start_acc)   err_timeout <= 1'b0;
      else if (to_hit) err_timeout <= 1'b1;

      if (start_acc)                              cycle_count <= '0;
      else if (busy && (cycle_count != 16'hFFFF)) cycle_count <= cycle_count + 16'd1;
    end
  end

  // Result buffer: beat j carries result[2j] in the upper word and
  // result[2j+1] in the lower word. Contents survive a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        result[i] <= '0;
      end
    end else if (rx_fire) begin
      result[{rx_cnt, 1'b0}] <= mac_data_out[63:32];
      result[{rx_cnt, 1'b1}] <= mac_data_out[31:0];
    end
  end

  // Registered read port; a same-cycle write is not forwarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_data <= '0;
    end else begin
      res_data <= result[res_addr];
    end
  end

endmodule

// File: doc/systolic_host_driver.md
Name: systolic_host_driver

Overview:
- Host-side counterpart of the 4x4 systolic MAC top.
- Latches two 4x4 signed int8 matrices (A, B) and arms the array with a one-cycle start strobe.
- Streams four 64-bit operand beats over the array's input valid/ready handshake, then drains eight 64-bit result beats from its output valid/ready handshake into a 16x32 result buffer.
- Exposes the result buffer through a registered read port, plus status and a cycle counter for the test/host environment.

Parameters:
- N_TX_BEATS, 4, operand beats per job.
- N_RX_BEATS, 8, result beats per job.
- TIMEOUT, 1024, max idle cycles waiting on a handshake before error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- cfg_a  in  128  matrix A, A[r][c] at bits [127-8*(4r+c) -: 8], signed.
- cfg_b  in  128  matrix B, same packing as cfg_a.
- start  in  1  job request, sampled in IDLE only.
- busy  out  1  high from start acceptance until the done/err cycle.
- done  out  1  one-cycle pulse when all results are captured.
- err_timeout  out  1  sticky timeout flag, cleared on next accepted start.
- mac_valid_in  out  1  one-cycle arm strobe to the array.
- mac_data  out  64  operand beat.
- mac_src_valid  out  1  operand beat valid.
- mac_dest_ready  in  1  array ready for operand beat.
- mac_dest_valid  in  1  array result beat valid.
- mac_data_out  in  64  result beat.
- mac_src_ready  out  1  driver ready for result beat.
- res_addr  in  4  result index, row*4+col.
- res_data  out  32  result word, registered, 1-cycle read latency.
- cycle_count  out  16  cycles from start acceptance to done, saturating at 16'hFFFF.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; beat/timeout counters 0; result buffer cleared to 0.
- IDLE:
  - start=1 latches cfg_a/cfg_b, clears err_timeout and cycle_count, and sets busy.
  - Next state ARM.
- ARM: mac_valid_in=1 for exactly one cycle -> SEND.
- SEND:
  - mac_src_valid=1 and mac_data = beat k, k=0..3.
  - Beat k: [63:32] = A[k][0..3] with A[k][0] at [63:56]; [31:0] = B[0..3][k] with B[0][k] at [31:24].
  - Transfer occurs on mac_src_valid & mac_dest_ready. mac_data must stay stable while valid and not ready.
  - k increments on each transfer. The transfer of k=3 goes to WAIT_RX with mac_src_valid=0 the following cycle.
- WAIT_RX:
  - mac_src_ready=1.
  - Each mac_dest_valid & mac_src_ready captures a beat j=0..7: [63:32] -> result[2j], [31:0] -> result[2j+1].
  - The capture of j=7 goes to FIN.
  - mac_dest_valid seen outside WAIT_RX is ignored; mac_src_ready=0 there.
- FIN: done=1 for one cycle, busy=0, return to IDLE. Buffer contents persist until the next job overwrites them.
- Timeout:
  - The counter resets on every handshake and on each state entry, and increments in SEND/WAIT_RX while no handshake occurs.
  - When the counter reaches TIMEOUT: err_timeout=1, go to IDLE (busy=0, no done pulse). The partially written buffer is retained.
- start while busy is ignored (no queueing).
- start and a FIN cycle coinciding: start is ignored, because the FSM is not in IDLE that cycle.
- cycle_count increments every cycle while busy and saturates; it holds its value in IDLE.
- res_data = result[res_addr] registered every cycle, independent of state. A read of a word written in the same cycle returns the old value.
- Result words are stored verbatim as signed 32-bit; no arithmetic in this block.
- Reset asserted mid-job aborts immediately: outputs 0 and state IDLE; the array side is re-reset by the shared reset.

Test Plan:
- A=identity, B[r][c]=4r+c, start -> four operand beats, beat0=64'h01000000_0004080C; after 8 result beats, result[i]=i for all 16 i; one done pulse.
- A=B=all 8'h80 (-128) -> every res_data=32'h00010000 (65536); err_timeout=0.
- Random backpressure: mac_dest_ready toggled 50% and mac_dest_valid bursty -> mac_data held stable during stalls, no beat lost or duplicated, results match golden model.
- mac_dest_ready held 0 after the first beat -> after 1024 stall cycles err_timeout=1, busy=0, no done; the next start clears err_timeout.
- start pulsed again in SEND with different cfg_a -> ignored; results match the first cfg_a.
- reset=0 in WAIT_RX after 3 captured beats -> immediately busy=0, mac_src_ready=0, res_data=0 after release; a new job then completes normally.
